wc_host_link: RTL and testbench

- Host-side counterpart of the WC_3_5 chip pin interface: drives the 10-bit D input bus and captures the 10-bit Z result bus.
- Accepts one whole input tile per valid/ready handshake and serializes it onto D, one word per cycle.
- Waits the fixed core latency, deserializes the result words from Z, and presents them as one output tile on a valid/ready handshake.
- Used in FPGA test harnesses and in the system-level bench that exercises the packaged chip.

---
 rtl/wc_host_link.sv | 129 ++++++++++++
 tb/tb_wc_host_link.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wc_host_link.sv
// Host-side link to the WC_3_5 pin interface.
// A tile of N_IN words is accepted in IDLE and shifted out on D, one word per
// cycle. After a fixed LAT-edge core latency, N_OUT consecutive Z samples are
// collected. The collected words are then offered as one output tile.
// Port rst is active-low and resets the block asynchronously.
module wc_host_link #(
  parameter int unsigned    DW        = 10,
  parameter int unsigned    N_IN      = 5,
  parameter int unsigned    N_OUT     = 3,
  parameter int unsigned    LAT       = 4,
  parameter logic [DW-1:0]  IDLE_WORD = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*N_IN-1:0]  in_data,
  output logic [DW-1:0]       D,
  input  logic [DW-1:0]       Z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*N_OUT-1:0] out_data,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned KW = $clog2(N_IN + 1);
  localparam int unsigned WW = $clog2(LAT + 2);
  localparam int unsigned RW = $clog2(N_OUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, HOLD} state_t;

  state_t             state;
  logic [DW*N_IN-1:0] shreg;
  logic [KW-1:0]      kcnt;
  logic [WW-1:0]      wcnt;
  logic [RW-1:0]      rcnt;

  // Frame sequencer: accept, serialize, wait, deserialize, hand off.
  // Z sample 0 is taken on the edge that leaves SEND (LAT=0) or WAIT, so RECV
  // only ever handles samples 1..N_OUT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      kcnt      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      D         <= IDLE_WORD;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            shreg    <= in_data >> DW;
            D        <= in_data[DW-1:0];
            kcnt     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SEND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SEND: begin
          if (kcnt == KW'(N_IN - 1)) begin
            D <= IDLE_WORD;
            if (LAT == 0) begin
              out_data[DW-1:0] <= Z;
              if (N_OUT == 1) begin
                out_valid <= 1'b1;
                state     <= HOLD;
              end else begin
                rcnt  <= RW'(1);
                state <= RECV;
              end
            end else begin
              wcnt  <= WW'(LAT);
              state <= WAIT;
            end
          end else begin
            D     <= shreg[DW-1:0];
            shreg <= shreg >> DW;
            kcnt  <= kcnt + KW'(1);
          end
        end
        WAIT: begin
          if (wcnt == WW'(1)) begin
            out_data[DW-1:0] <= Z;
            if (N_OUT == 1) begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              rcnt  <= RW'(1);
              state <= RECV;
            end
          end else begin
            wcnt <= wcnt - WW'(1);
          end
        end
        RECV: begin
          for (int unsigned j = 0; j < N_OUT; j++) begin
            if (rcnt == RW'(j)) out_data[j*DW +: DW] <= Z;
          end
          if (rcnt == RW'(N_OUT - 1)) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wc_host_link.sv
// Bench for wc_host_link. A timeline model driven by the accept edge predicts
// every output. It is checked on each falling edge and backed by hand-computed
// literal expectations. A second instance covers the LAT=0, N_IN=1, N_OUT=1 build.
module tb_wc_host_link;
  localparam int DW    = 10;
  localparam int N_IN  = 5;
  localparam int N_OUT = 3;
  localparam int LAT   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic [DW*N_IN-1:0]  in_data = '0;
  logic                in_ready;
  logic [DW-1:0]       D;
  logic [DW-1:0]       Z;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW*N_OUT-1:0] out_data;
  logic                busy;
  logic [15:0]         frame_cnt;

  logic        b_in_valid = 1'b0;
  logic [9:0]  b_in_data = '0;
  logic        b_in_ready;
  logic [9:0]  b_D;
  logic [9:0]  b_Z = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [9:0]  b_out_data;
  logic        b_busy;
  logic [15:0] b_frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wc_host_link #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .LAT(LAT), .IDLE_WORD(10'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .D(D), .Z(Z), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  wc_host_link #(.DW(10), .N_IN(1), .N_OUT(1), .LAT(0), .IDLE_WORD(10'd0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .D(b_D), .Z(b_Z), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .frame_cnt(b_frame_cnt)
  );

  // Chip stand-in: Z echoes D through an 8-stage pipe, XORed with 0x2A0, so
  // word k reaches Z exactly when sample k is due with N_IN=5, LAT=4.
  logic [DW-1:0] zp [8];
  always @(posedge clk) begin
    zp[0] <= D;
    for (int i = 1; i < 8; i++) zp[i] <= zp[i-1];
  end
  assign Z = zp[7] ^ 10'h2A0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW*N_IN-1:0] tile(input int t);
    logic [DW*N_IN-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*DW +: DW] = DW'(16*t + k + 1);
    return r;
  endfunction

  // Timeline model: everything follows from the accept edge e0.
  int            mcyc = 0;
  int            e0 = 0;
  bit            m_idle = 1'b1;
  bit            m_armed = 1'b0;
  bit            m_valid = 1'b0;
  logic [15:0]   m_frames = '0;
  logic [DW-1:0] m_d = '0;
  logic [DW-1:0] m_words [N_IN];
  logic [DW-1:0] m_slot [N_OUT];
  int            preload_req = 0;
  int            preload_seen = 0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_idle = 1'b1; m_armed = 1'b0; m_valid = 1'b0; m_frames = '0; m_d = '0;
    end else begin
      int rel, j;
      mcyc++;
      if (preload_req != preload_seen) begin
        preload_seen = preload_req;
        m_frames = 16'hFFFF;
      end
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0; m_frames = m_frames + 16'd1; m_idle = 1'b1; m_armed = 1'b0;
        end
      end else if (m_idle) begin
        if (m_armed && in_valid) begin
          m_idle = 1'b0; m_armed = 1'b0; e0 = mcyc;
          for (int k = 0; k < N_IN; k++) m_words[k] = in_data[k*DW +: DW];
        end else begin
          m_armed = 1'b1;
        end
      end else begin
        rel = mcyc - e0;
        j = rel - (N_IN + LAT);
        if (j >= 0 && j < N_OUT) m_slot[j] = Z;
        if (j == N_OUT - 1) m_valid = 1'b1;
      end
      m_d = '0;
      if (!m_idle && (mcyc - e0) < N_IN) m_d = m_words[mcyc - e0];
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  logic [DW*N_OUT-1:0] exp_out;
  initial forever begin
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(m_idle && m_armed));
    check("busy", 64'(busy), 64'(!m_idle));
    check("D", 64'(D), 64'(m_d));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    if (m_valid) begin
      for (int j = 0; j < N_OUT; j++) exp_out[j*DW +: DW] = m_slot[j];
      check("out_data", 64'(out_data), 64'(exp_out));
    end
  end

  initial begin
    #50000;
    errors++; checks++;
    $display("FAIL timeout: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int acc_t [3];
    int n, guard;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_D", 64'(D), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(in_ready), 64'd1);

    // Single tile 1..5
    in_data = {10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_D0", 64'(D), 64'd1);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("t1_Dk", 64'(D), 64'(k + 1));
    end
    @(negedge clk);
    check("t1_D_idle", 64'(D), 64'd0);
    repeat (5) @(negedge clk);
    check("t1_valid_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_out_data", 64'(out_data), 64'({10'h2A3, 10'h2A2, 10'h2A1}));
    check("t1_busy", 64'(busy), 64'd1);

    // Stall in HOLD for 20 cycles
    repeat (20) @(negedge clk);
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_data", 64'(out_data), 64'({10'h2A3, 10'h2A2, 10'h2A1}));
    check("t2_in_ready", 64'(in_ready), 64'd0);
    check("t2_D", 64'(D), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t2_valid_drop", 64'(out_valid), 64'd0);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t2_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t2_ready_back", 64'(in_ready), 64'd1);

    // Three queued tiles, in_valid held, out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1;
    n = 0; guard = 0;
    while (n < 3 && guard < 200) begin
      in_data = tile(n + 1);
      if (in_ready) begin
        acc_t[n] = mcyc + 1;
        n++;
      end
      if (n < 3) begin
        @(negedge clk);
        guard++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_accepts", 64'(n), 64'd3);
    if (n == 3) begin
      check("t3_gap01", 64'(acc_t[1] - acc_t[0]), 64'd14);
      check("t3_gap12", 64'(acc_t[2] - acc_t[1]), 64'd14);
    end
    repeat (20) @(negedge clk);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd4);
    out_ready = 1'b0;

    // Reset during the 3rd SEND cycle
    check("t4_ready", 64'(in_ready), 64'd1);
    in_data = tile(10);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_D_word2", 64'(D), 64'd163);
    #1 rst = 1'b0;
    #1;
    check("t4_rst_D", 64'(D), 64'd0);
    check("t4_rst_valid", 64'(out_valid), 64'd0);
    check("t4_rst_frame", 64'(frame_cnt), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_data = tile(11);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_fresh_frame", 64'(frame_cnt), 64'd1);

    // frame_cnt wrap from 0xFFFF
    #2;
    force dut.frame_cnt = 16'hFFFF;
    preload_req++;
    #1 release dut.frame_cnt;
    @(negedge clk);
    in_data = tile(12);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_wrap", 64'(frame_cnt), 64'd0);
    out_ready = 1'b0;

    // Minimal build: LAT=0, N_IN=1, N_OUT=1
    b_Z = 10'h155;
    b_in_data = 10'h3FF;
    b_in_valid = 1'b1;
    check("b_ready", 64'(b_in_ready), 64'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    check("b_D", 64'(b_D), 64'h3FF);
    check("b_busy", 64'(b_busy), 64'd1);
    check("b_valid_early", 64'(b_out_valid), 64'd0);
    b_Z = 10'h2AA;
    @(negedge clk);
    check("b_D_idle", 64'(b_D), 64'd0);
    check("b_valid", 64'(b_out_valid), 64'd1);
    check("b_out_data", 64'(b_out_data), 64'h2AA);
    b_Z = 10'h111;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_valid_drop", 64'(b_out_valid), 64'd0);
    check("b_frame", 64'(b_frame_cnt), 64'd1);
    check("b_data_hold", 64'(b_out_data), 64'h2AA);
    check("b_ready_low", 64'(b_in_ready), 64'd0);
    @(negedge clk);
    check("b_ready_back", 64'(b_in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
